// File: rtl/multi_port_ordered_fifo_if.sv
// Multi-lane push/pop stream bundle with occupancy status for multi_port_ordered_fifo.
interface multi_port_ordered_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENQ_WIDTH  = 2,
  parameter int unsigned DEQ_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH  = 4
);
  logic                            flush;
  logic [ENQ_WIDTH-1:0]            enq_vld;
  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_payload;
  logic [ENQ_WIDTH-1:0]            enq_rdy;
  logic [DEQ_WIDTH-1:0]            deq_vld;
  logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_payload;
  logic [DEQ_WIDTH-1:0]            deq_rdy;
  logic [CNT_WIDTH-1:0]            count;
  logic                            empty;
  logic                            full;
  logic                            afull;

  modport master (
    output flush, enq_vld, enq_payload, deq_rdy,
    input  enq_rdy, deq_vld, deq_payload, count, empty, full, afull
  );

  modport slave (
    input  flush, enq_vld, enq_payload, deq_rdy,
    output enq_rdy, deq_vld, deq_payload, count, empty, full, afull
  );
endinterface

// File: rtl/multi_port_ordered_fifo.sv
// In-order multi-port FIFO: compacted multi-lane enqueue, head-aligned multi-lane
// prefix-only dequeue, registered occupancy and status.
module multi_port_ordered_fifo #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ENQ_WIDTH    = 2,
  parameter int unsigned DEQ_WIDTH    = 2,
  parameter bit          TAKEN_ALL    = 1'b0,
  parameter int          AFULL_THRESH = int'(DEPTH) - int'(ENQ_WIDTH)
) (
  input logic                     clk,
  input logic                     rst,
  multi_port_ordered_fifo_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t                  head_q, tail_q, head_d, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ENQ_WIDTH-1:0]  enq_rdy, enq_fire;
  logic [DEQ_WIDTH-1:0]  deq_vld, deq_fire;
  ptr_t                  widx [ENQ_WIDTH];
  ptr_t                  ridx [DEQ_WIDTH];
  logic [31:0]           n_enq, n_deq, used, free, ptr_diff;
  logic                  go;

  // Inputs never exceed 2*DEPTH-1, so one compare-and-subtract wraps any DEPTH.
  function automatic ptr_t wrap_add(input ptr_t base, input logic [31:0] inc);
    logic [31:0] s;
    s = 32'(base) + inc;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  always_comb begin
    used  = 32'(count_q);
    free  = DEPTH - used;
    n_enq = '0;
    n_deq = '0;
    go    = 1'b1;
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      enq_rdy[i]  = ~bus.flush & (TAKEN_ALL ? (free >= ENQ_WIDTH) : (free > i));
      enq_fire[i] = bus.enq_vld[i] & enq_rdy[i];
      widx[i]     = wrap_add(tail_q, n_enq);
      if (enq_fire[i]) n_enq = n_enq + 32'd1;
    end
    // A pop lane fires only if every lower lane fired, so deq_rdy holes end the pop.
    for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
      deq_vld[i]  = ~bus.flush & (used > i);
      ridx[i]     = wrap_add(head_q, i);
      deq_fire[i] = deq_vld[i] & bus.deq_rdy[i] & go;
      go          = deq_fire[i];
      if (deq_fire[i]) n_deq = n_deq + 32'd1;
    end
    head_d  = wrap_add(head_q, n_deq);
    tail_d  = wrap_add(tail_q, n_enq);
    count_d = CW'(used + n_enq - n_deq);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    bus.deq_payload = '0;
    for (int unsigned i = 0; i < DEQ_WIDTH; i++)
      bus.deq_payload[i*DATA_WIDTH +: DATA_WIDTH] = mem[ridx[i]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_WIDTH; i++)
      if (enq_fire[i]) mem[widx[i]] <= bus.enq_payload[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.enq_rdy = enq_rdy;
  assign bus.deq_vld = deq_vld;
  assign bus.count   = count_q;
  assign bus.empty   = (count_q == '0);
  assign bus.full    = (used == DEPTH);
  assign bus.afull   = (int'(used) >= AFULL_THRESH);

  assign ptr_diff = (32'(tail_q) + DEPTH - 32'(head_q)) % DEPTH;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) used <= DEPTH);
  a_ptr_count:   assert property (@(posedge clk) disable iff (rst) ptr_diff == (used % DEPTH));
endmodule

// File: tb/tb_multi_port_ordered_fifo.sv
// Directed bench for multi_port_ordered_fifo: DEPTH=8 instance for the main tests,
// DEPTH=5 instance checked against a queue model across pointer wrap.
module tb_multi_port_ordered_fifo;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  multi_port_ordered_fifo_if #(.DATA_WIDTH(32), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .CNT_WIDTH(4)) b8 ();
  multi_port_ordered_fifo_if #(.DATA_WIDTH(32), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .CNT_WIDTH(3)) b5 ();

  multi_port_ordered_fifo #(.DEPTH(8), .DATA_WIDTH(32), .ENQ_WIDTH(2), .DEQ_WIDTH(2),
                            .TAKEN_ALL(1'b0), .AFULL_THRESH(6))
    dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  multi_port_ordered_fifo #(.DEPTH(5), .DATA_WIDTH(32), .ENQ_WIDTH(2), .DEQ_WIDTH(2),
                            .TAKEN_ALL(1'b0), .AFULL_THRESH(3))
    dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push8(input logic [1:0] vld, input logic [31:0] l1, input logic [31:0] l0);
    b8.enq_vld     = vld;
    b8.enq_payload = {l1, l0};
    tick();
    b8.enq_vld = 2'b00;
  endtask

  logic [1:0] ep [12];
  logic [1:0] dp [12];
  int         q [$];
  int unsigned nxt;
  int unsigned cnt;
  int unsigned fr;
  logic        d0;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    b8.flush = 1'b0; b8.enq_vld = '0; b8.enq_payload = '0; b8.deq_rdy = '0;
    b5.flush = 1'b0; b5.enq_vld = '0; b5.enq_payload = '0; b5.deq_rdy = '0;
    #2;
    chk("rst_count", 32'(b8.count), 32'd0);
    chk("rst_empty", 32'(b8.empty), 32'd1);
    chk("rst_full",  32'(b8.full),  32'd0);
    chk("rst_afull", 32'(b8.afull), 32'd0);
    chk("rst_dvld",  32'(b8.deq_vld), 32'd0);
    chk("rst_erdy",  32'(b8.enq_rdy), 32'd3);
    tick();
    rst = 1'b0;
    tick();

    // compaction: only lane 1 valid
    push8(2'b10, 32'hA5, 32'hDEAD);
    #1;
    chk("cmp_dvld", 32'(b8.deq_vld), 32'd1);
    chk("cmp_pay0", b8.deq_payload[31:0], 32'hA5);
    chk("cmp_count", 32'(b8.count), 32'd1);
    b8.deq_rdy = 2'b01;
    tick();
    b8.deq_rdy = 2'b00;
    #1;
    chk("cmp_empty", 32'(b8.empty), 32'd1);

    // fill to full with 0..7
    for (int k = 0; k < 4; k++) begin
      b8.enq_vld     = 2'b11;
      b8.enq_payload = {32'(2*k+1), 32'(2*k)};
      #1;
      chk("fill_erdy", 32'(b8.enq_rdy), 32'd3);
      tick();
      b8.enq_vld = 2'b00;
      #1;
      chk("fill_count", 32'(b8.count), 32'(2*(k+1)));
      chk("fill_afull", 32'(b8.afull), (2*(k+1) >= 6) ? 32'd1 : 32'd0);
    end
    chk("full_full", 32'(b8.full), 32'd1);
    chk("full_erdy", 32'(b8.enq_rdy), 32'd0);
    chk("full_dvld", 32'(b8.deq_vld), 32'd3);
    chk("full_pay0", b8.deq_payload[31:0], 32'd0);
    chk("full_pay1", b8.deq_payload[63:32], 32'd1);

    // push+pop while full: pop wins, push refused
    b8.enq_vld = 2'b11; b8.enq_payload = {32'h99, 32'h98}; b8.deq_rdy = 2'b11;
    #1;
    chk("fpp_erdy", 32'(b8.enq_rdy), 32'd0);
    tick();
    b8.enq_vld = 2'b00; b8.deq_rdy = 2'b00;
    #1;
    chk("fpp_count", 32'(b8.count), 32'd6);
    chk("fpp_pay0", b8.deq_payload[31:0], 32'd2);
    chk("fpp_full", 32'(b8.full), 32'd0);

    b8.flush = 1'b1;
    tick();
    b8.flush = 1'b0;
    #1;
    chk("fl1_count", 32'(b8.count), 32'd0);

    // prefix-only pop
    push8(2'b11, 32'd1, 32'd0);
    push8(2'b01, 32'd0, 32'd2);
    #1;
    chk("pfx_count3", 32'(b8.count), 32'd3);
    b8.deq_rdy = 2'b10;
    #1;
    chk("pfx_dvld", 32'(b8.deq_vld), 32'd3);
    tick();
    b8.deq_rdy = 2'b00;
    #1;
    chk("pfx_nopop_count", 32'(b8.count), 32'd3);
    chk("pfx_nopop_pay0", b8.deq_payload[31:0], 32'd0);
    b8.deq_rdy = 2'b11;
    tick();
    b8.deq_rdy = 2'b00;
    #1;
    chk("pfx_pop_count", 32'(b8.count), 32'd1);
    chk("pfx_pop_pay0", b8.deq_payload[31:0], 32'd2);
    chk("pfx_pop_dvld", 32'(b8.deq_vld), 32'd1);

    // flush beats a same-cycle push
    push8(2'b11, 32'd4, 32'd3);
    push8(2'b10, 32'd5, 32'd0);
    #1;
    chk("fl_count4", 32'(b8.count), 32'd4);
    chk("fl_pay1", b8.deq_payload[63:32], 32'd3);
    b8.flush = 1'b1; b8.enq_vld = 2'b11; b8.enq_payload = {32'hEE, 32'hEF};
    #1;
    chk("fl_erdy", 32'(b8.enq_rdy), 32'd0);
    chk("fl_dvld", 32'(b8.deq_vld), 32'd0);
    tick();
    b8.flush = 1'b0; b8.enq_vld = 2'b00;
    #1;
    chk("fl_count0", 32'(b8.count), 32'd0);
    chk("fl_empty", 32'(b8.empty), 32'd1);
    push8(2'b01, 32'd0, 32'h77);
    #1;
    chk("fl_after_dvld", 32'(b8.deq_vld), 32'd1);
    chk("fl_after_pay0", b8.deq_payload[31:0], 32'h77);

    // async reset mid-traffic at count 5
    push8(2'b11, 32'd9, 32'd8);
    push8(2'b11, 32'd11, 32'd10);
    #1;
    chk("ar_count5", 32'(b8.count), 32'd5);
    rst = 1'b1;
    #1;
    chk("ar_count", 32'(b8.count), 32'd0);
    chk("ar_empty", 32'(b8.empty), 32'd1);
    chk("ar_dvld", 32'(b8.deq_vld), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // DEPTH=5 wrap against queue model
    ep = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00};
    dp = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11};
    nxt = 100;
    for (int c = 0; c < 12; c++) begin
      b5.enq_vld     = ep[c];
      b5.enq_payload = {32'(nxt + 1), 32'(nxt)};
      b5.deq_rdy     = dp[c];
      #1;
      cnt = q.size();
      fr  = 5 - cnt;
      chk("w5_count", 32'(b5.count), 32'(cnt));
      chk("w5_dvld", 32'(b5.deq_vld), {30'd0, cnt > 1, cnt > 0});
      chk("w5_erdy", 32'(b5.enq_rdy), {30'd0, fr > 1, fr > 0});
      if (cnt > 0) chk("w5_pay0", b5.deq_payload[31:0], 32'(q[0]));
      if (cnt > 1) chk("w5_pay1", b5.deq_payload[63:32], 32'(q[1]));
      d0 = dp[c][0] && cnt > 0;
      if (d0) void'(q.pop_front());
      if (d0 && dp[c][1] && cnt > 1) void'(q.pop_front());
      if (ep[c][0] && fr > 0) q.push_back(int'(nxt));
      if (ep[c][1] && fr > 1) q.push_back(int'(nxt + 1));
      nxt = nxt + 2;
      tick();
    end
    b5.enq_vld = 2'b00; b5.deq_rdy = 2'b00;
    #1;
    chk("w5_final_count", 32'(b5.count), 32'(q.size()));
    if (q.size() > 0) chk("w5_final_pay0", b5.deq_payload[31:0], 32'(q[0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
